multi_slow_edge_trigger: RTL and testbench

//  Parametrised multi-channel successor to the single slow-clock trigger.

---
 rtl/slow_trigger_pkg.sv | 28 ++
 rtl/edge_trigger_channel.sv | 127 ++++++++++++
 rtl/multi_slow_edge_trigger.sv | 70 +++++++
 tb/tb_multi_slow_edge_trigger.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/slow_trigger_pkg.sv
// Shared types and edge-select helper for the multi-channel slow edge trigger.
package slow_trigger_pkg;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'b00,
        EDGE_FALL = 2'b01,
        EDGE_BOTH = 2'b10,
        EDGE_OFF  = 2'b11
    } edge_mode_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_PULSE = 1'b1
    } state_t;

    function automatic logic select_edge(edge_mode_t mode, logic rise, logic fall);
        logic sel;
        sel = 1'b0;
        case (mode)
            EDGE_RISE: sel = rise;
            EDGE_FALL: sel = fall;
            EDGE_BOTH: sel = rise | fall;
            default:   sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/edge_trigger_channel.sv
// One channel: synchroniser, edge detector, pulse FSM, sticky overrun flag and,
// with MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN, a saturating accepted-edge counter.
module edge_trigger_channel
    import slow_trigger_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PULSE_CYCLES = 1
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
    ,
    parameter int unsigned CNT_W        = 8
`endif
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_slow,
    input  logic             i_armed,
    input  logic [1:0]       i_mode,
    input  logic             i_clr_overrun,
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
    output logic [CNT_W-1:0] o_event_count,
`endif
    output logic             o_trigger,
    output logic             o_busy,
    output logic             o_overrun
);

    localparam int unsigned PCW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
    localparam logic [PCW-1:0] PULSE_LOAD = PCW'(PULSE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    state_t                 r_state;
    state_t                 w_state_next;
    logic [PCW-1:0]         r_pcnt;
    logic [PCW-1:0]         w_pcnt_next;
    logic                   r_overrun;
    logic                   w_overrun_set;
    logic                   w_sync_out;
    logic                   w_edge;

    // prev follows the synchroniser even while unarmed, so levels held through reset are ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= '0;
            r_prev <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_slow};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];
    assign w_edge     = i_armed & select_edge(edge_mode_t'(i_mode),
                                              w_sync_out & ~r_prev,
                                              ~w_sync_out & r_prev);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_pcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_pcnt  <= w_pcnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_pcnt_next   = r_pcnt;
        w_overrun_set = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_next = ST_PULSE;
                    w_pcnt_next  = PULSE_LOAD;
                end
            end
            ST_PULSE: begin
                // Only the final pulse cycle may re-arm; earlier edges are lost and flagged.
                if (r_pcnt == '0) begin
                    if (w_edge) begin
                        w_pcnt_next = PULSE_LOAD;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else begin
                    w_pcnt_next   = r_pcnt - 1'b1;
                    w_overrun_set = w_edge;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_trigger = (r_state == ST_PULSE);
        o_busy    = (r_state == ST_PULSE);
        o_overrun = r_overrun;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overrun <= 1'b0;
        end else if (w_overrun_set) begin
            r_overrun <= 1'b1;
        end else if (i_clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
    logic [CNT_W-1:0] r_event_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_event_cnt <= '0;
        end else if (w_edge && (r_event_cnt != {CNT_W{1'b1}})) begin
            r_event_cnt <= r_event_cnt + 1'b1;
        end
    end

    assign o_event_count = r_event_cnt;
`endif

endmodule

// File: rtl/multi_slow_edge_trigger.sv
// Multi-channel slow-signal edge trigger: shared post-reset warm-up plus one channel per input.
// Optional per-channel event counters via MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN.
module multi_slow_edge_trigger
    import slow_trigger_pkg::*;
#(
    parameter int unsigned CHANNELS     = 4,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                      fastClock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       slowIn,
    input  logic [1:0]                edgeMode,
    input  logic                      clearOverrun,
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
    output logic [CHANNELS*CNT_W-1:0] eventCount,
`endif
    output logic [CHANNELS-1:0]       trigger,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS-1:0]       overrun
);

    localparam int unsigned WW = $clog2(SYNC_STAGES + 2);
    localparam logic [WW-1:0] WARM_DONE = WW'(SYNC_STAGES + 1);

    logic [WW-1:0] r_warm;
    logic          w_armed;

    // Holds off detection until every synchroniser stage and prev carry post-reset samples.
    always_ff @(posedge fastClock) begin
        if (reset) begin
            r_warm <= '0;
        end else if (r_warm != WARM_DONE) begin
            r_warm <= r_warm + 1'b1;
        end
    end

    assign w_armed = (r_warm == WARM_DONE);

`ifndef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
    logic w_unused_cnt_w;
    assign w_unused_cnt_w = |CNT_W;
`endif

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
        edge_trigger_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .PULSE_CYCLES (PULSE_CYCLES)
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
            ,
            .CNT_W        (CNT_W)
`endif
        ) u_chan (
            .i_clk         (fastClock),
            .i_rst         (reset),
            .i_slow        (slowIn[ch]),
            .i_armed       (w_armed),
            .i_mode        (edgeMode),
            .i_clr_overrun (clearOverrun),
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
            .o_event_count (eventCount[ch*CNT_W +: CNT_W]),
`endif
            .o_trigger     (trigger[ch]),
            .o_busy        (busy[ch]),
            .o_overrun     (overrun[ch])
        );
    end

endmodule

// File: tb/tb_multi_slow_edge_trigger.sv
// Directed bench: three instances (pulse widths 1, 4, 3) sharing one stimulus stream.
module tb_multi_slow_edge_trigger;

    logic       clk;
    logic       rst;
    logic [3:0] slow_in;
    logic [1:0] mode;
    logic       clr;

    logic [3:0] t1, b1, o1;
    logic [3:0] t4, b4, o4;
    logic [3:0] t3, b3, o3;
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
    logic [11:0] ec1, ec4, ec3;
`endif

    int n_vec = 0;
    int n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    multi_slow_edge_trigger #(
        .CHANNELS(4), .SYNC_STAGES(2), .PULSE_CYCLES(1), .CNT_W(3)
    ) u_p1 (
        .fastClock    (clk),
        .reset        (rst),
        .slowIn       (slow_in),
        .edgeMode     (mode),
        .clearOverrun (clr),
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
        .eventCount   (ec1),
`endif
        .trigger      (t1),
        .busy         (b1),
        .overrun      (o1)
    );

    multi_slow_edge_trigger #(
        .CHANNELS(4), .SYNC_STAGES(2), .PULSE_CYCLES(4), .CNT_W(3)
    ) u_p4 (
        .fastClock    (clk),
        .reset        (rst),
        .slowIn       (slow_in),
        .edgeMode     (mode),
        .clearOverrun (clr),
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
        .eventCount   (ec4),
`endif
        .trigger      (t4),
        .busy         (b4),
        .overrun      (o4)
    );

    multi_slow_edge_trigger #(
        .CHANNELS(4), .SYNC_STAGES(2), .PULSE_CYCLES(3), .CNT_W(3)
    ) u_p3 (
        .fastClock    (clk),
        .reset        (rst),
        .slowIn       (slow_in),
        .edgeMode     (mode),
        .clearOverrun (clr),
`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
        .eventCount   (ec3),
`endif
        .trigger      (t3),
        .busy         (b3),
        .overrun      (o3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst     = 1'b1;
        slow_in = 4'h0;
        mode    = 2'b00;
        clr     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_trig_p1", t1, 4'h0);
        check("rst_busy_p1", b1, 4'h0);
        check("rst_ovr_p1", o1, 4'h0);
        check("rst_trig_p4", t4, 4'h0);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        // Rise on ch0: trigger two edges after first sample
        slow_in = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rise_trig_p1", t1, (i == 2) ? 4'b0001 : 4'b0000);
            check("rise_busy_p1", b1, (i == 2) ? 4'b0001 : 4'b0000);
            check("rise_trig_p4", t4, (i >= 2 && i <= 5) ? 4'b0001 : 4'b0000);
        end
        slow_in = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("rise_ignores_fall", t1, 4'h0);
        end

        // Inputs high through reset: warm-up hides the apparent rise
        rst     = 1'b1;
        slow_in = 4'hF;
        for (int i = 0; i < 3; i++) tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("warmup_p1", t1, 4'h0);
            check("warmup_p4", t4, 4'h0);
        end
        mode    = 2'b01;
        slow_in = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("fall_trig_p1", t1, (i == 2) ? 4'b0100 : 4'b0000);
            check("fall_trig_p4", t4, (i >= 2 && i <= 5) ? 4'b0100 : 4'b0000);
        end

        // Both-edge mode, ch1 toggled twice two cycles apart
        mode = 2'b10;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) slow_in[1] = 1'b0;
            if (i == 2) slow_in[1] = 1'b1;
            tick();
            check("ovr_trig_p4", t4, (i >= 2 && i <= 5) ? 4'b0010 : 4'b0000);
            check("ovr_flag_p4", o4, (i >= 4) ? 4'b0010 : 4'b0000);
            check("b2b_trig_p1", t1, (i == 2 || i == 4) ? 4'b0010 : 4'b0000);
            check("b2b_ovr_p1", o1, 4'h0);
        end
        check("ovr_flag_p3", o3, 4'b0010);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_ovr_p4", o4, 4'h0);
        check("clr_ovr_p3", o3, 4'h0);

        // Second edge lands in the final cycle of a width-3 pulse
        for (int i = 0; i < 11; i++) begin
            if (i == 0) slow_in[1] = 1'b0;
            if (i == 3) slow_in[1] = 1'b1;
            tick();
            check("extend_busy_p3", b3, (i >= 2 && i <= 7) ? 4'b0010 : 4'b0000);
        end
        check("extend_ovr_p3", o3, 4'h0);
        check("extend_ovr_p4", o4, 4'b0010);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr2_ovr_p4", o4, 4'h0);

        // Disabled mode with toggling ch0, then switch to rise mid-stream
        mode = 2'b11;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) mode = 2'b00;
            slow_in[0] = ((i >> 1) & 1) != 0;
            tick();
            check("mode_sw_trig_p1", t1, (i == 8) ? 4'b0001 : 4'b0000);
        end
        check("mid_pulse_p4", t4, 4'b0001);
        rst = 1'b1;
        tick();
        check("rst_mid_trig_p4", t4, 4'h0);
        check("rst_mid_busy_p4", b4, 4'h0);

`ifdef MULTI_SLOW_EDGE_TRIGGER_EVENT_COUNT_EN
        slow_in = 4'h0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        for (int r = 0; r < 10; r++) begin
            slow_in[3] = 1'b1;
            tick();
            tick();
            slow_in[3] = 1'b0;
            tick();
            tick();
            if (r == 2) check("evcnt_three", ec1[11:9], 3'd3);
        end
        for (int i = 0; i < 3; i++) tick();
        check("evcnt_sat_p1", ec1[11:9], 3'd7);
        check("evcnt_sat_p4", ec4[11:9], 3'd7);
        check("evcnt_ch0", ec1[2:0], 3'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
